// File: rtl/vp_pkg.sv
// Shared definitions for the vector-processor instruction sequencer:
// instruction word layout, opcode values, FSM states and hold-time lookup.
package vp_pkg;

  localparam int INSTR_W = 13;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  // Field positions inside an instruction word
  localparam int OPC_HI  = 12;
  localparam int OPC_LO  = 11;
  localparam int REG_HI  = 10;
  localparam int REG_LO  = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Number of cycles an instruction with opcode opc stays on the bus
  function automatic int hold_cycles(input logic [1:0] opc,
                                     input int load_cyc,
                                     input int store_cyc,
                                     input int alu_cyc);
    case (opc)
      OP_LOAD:        return load_cyc;
      OP_STORE:       return store_cyc;
      OP_ADD, OP_MUL: return alu_cyc;
      default:        return alu_cyc;
    endcase
  endfunction

endpackage

// File: rtl/vp_prog_buffer.sv
// Program buffer: DEPTH instruction words, synchronous write, asynchronous
// read so the sequencer can register the word in the same cycle it decides
// to issue it.
module vp_prog_buffer
  import vp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vp_instr_sequencer.sv
// Instruction sequencer: runs a stored program onto the processor's
// instruction bus, holding each word for an opcode-dependent number of
// cycles with no gaps between consecutive words.
module vp_instr_sequencer
  import vp_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int LOAD_CYC  = 3,
  parameter int STORE_CYC = 2,
  parameter int ALU_CYC   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               halt,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic               halted,
  output logic               prog_err,
  output logic [AW-1:0]      pc
);

  localparam int MAX_LS = (LOAD_CYC > STORE_CYC) ? LOAD_CYC : STORE_CYC;
  localparam int MAX_W  = (MAX_LS > ALU_CYC) ? MAX_LS : ALU_CYC;
  localparam int CW     = $clog2(MAX_W) + 1;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  seq_state_t         state_reg, state_next;
  logic [AW-1:0]      pc_reg;
  logic [AW:0]        len_reg;
  logic [CW-1:0]      cnt_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg, busy_reg, done_reg, halted_reg, prog_err_reg;
  logic               halt_pend_reg;

  logic               run_active, busy_next, is_last, stop_req;
  logic               issue, capture_len;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic [AW:0]        len_clamped, len_m1;
  logic [CW-1:0]      hold_load;

  assign run_active  = (state_reg == ST_ISSUE) || (state_reg == ST_HOLD);
  assign busy_next   = (state_next == ST_ISSUE) || (state_next == ST_HOLD);
  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign len_m1      = len_reg - 1'b1;
  assign is_last     = ({1'b0, pc_reg} == len_m1);
  // A halt seen on the final cycle of an instruction takes effect at once
  assign stop_req    = halt_pend_reg | halt;
  assign hold_load   = CW'(hold_cycles(rd_data[OPC_HI:OPC_LO],
                                       LOAD_CYC, STORE_CYC, ALU_CYC) - 1);

  vp_prog_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (prog_we && !run_active),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state decision; "issue" loads the next word onto the bus so it
  // appears directly after the previous word's last hold cycle
  always_comb begin
    state_next  = state_reg;
    issue       = 1'b0;
    capture_len = 1'b0;
    rd_addr     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          capture_len = 1'b1;
          if (len_clamped != '0) begin
            issue      = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_ISSUE, ST_HOLD: begin
        if (cnt_reg == '0) begin
          if (is_last || stop_req) begin
            state_next = ST_DONE;
          end else begin
            issue      = 1'b1;
            rd_addr    = pc_reg + 1'b1;
            state_next = ST_ISSUE;
          end
        end else begin
          state_next = ST_HOLD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      instr_reg     <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      halted_reg    <= 1'b0;
      prog_err_reg  <= 1'b0;
      halt_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= busy_next;
      done_reg      <= (state_next == ST_DONE);
      halted_reg    <= (state_next == ST_DONE) && run_active && stop_req;
      prog_err_reg  <= prog_we && run_active;
      halt_pend_reg <= busy_next ? (halt_pend_reg | (run_active & halt)) : 1'b0;
      if (capture_len) begin
        len_reg <= len_clamped;
      end
      if (issue) begin
        instr_reg <= rd_data;
        valid_reg <= 1'b1;
        pc_reg    <= rd_addr;
        cnt_reg   <= hold_load;
      end else begin
        if (run_active && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
        if (state_next == ST_DONE) begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign instruction = instr_reg;
  assign instr_valid = valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign halted      = halted_reg;
  assign prog_err    = prog_err_reg;
  assign pc          = pc_reg;

endmodule
